seg_scan_ctrl: RTL and testbench

//  4-digit time-multiplexed scan controller; sits directly upstream of the seven_segement decoder.

---
 rtl/seg_scan_ctrl_if.sv | 41 ++++
 rtl/seg_scan_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
//  Bundles the host-side load/data signals and the decoder-side scan outputs
//  of seg_scan_ctrl.
//  master : the environment (host + decoder); drives load/data/masks and
//           observes the scan outputs.
//  slave  : seg_scan_ctrl itself.
//  Signals:
//   load        1   capture strobe for data_in/dp_mask/blink_mask
//   data_in     16  digit3=[15:12] .. digit0=[3:0]
//   dp_mask     4   decimal point per digit
//   blink_mask  4   blink request per digit
//   digit_bin   4   nibble of the digit currently scanned
//   digit_dp_en 1   decimal point of the digit currently scanned
//   digit_blink 1   blink request of the digit currently scanned
//   digit_sel   4   one-hot digit enable (polarity set by the controller)
//   upd_pending 1   pending buffer holds data not yet shown
//   frame_done  1   pulse on the last cycle of the digit-3 slot
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  digit_bin;
  logic        digit_dp_en;
  logic        digit_blink;
  logic [3:0]  digit_sel;
  logic        upd_pending;
  logic        frame_done;

  modport master (
    output load, data_in, dp_mask, blink_mask,
    input  digit_bin, digit_dp_en, digit_blink, digit_sel, upd_pending, frame_done
  );

  modport slave (
    input  load, data_in, dp_mask, blink_mask,
    output digit_bin, digit_dp_en, digit_blink, digit_sel, upd_pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//  Four-digit time-multiplexed scan controller feeding a seven-segment
//  decoder. Holds a double-buffered 16-bit display word with per-digit
//  decimal-point and blink masks; new data is copied from the pending
//  buffer to the active buffer only at frame boundaries.
//  Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  seg_scan_ctrl_if.slave (load/data/masks in, scan outputs out)
//  Parameters:
//   SCAN_DIV        clocks per digit slot (>= 2)
//   CNT_W           slot counter width (must hold SCAN_DIV-1)
//   SEL_ACTIVE_LOW  1: digit_sel active-low
//  Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading-zero digits 3..1 are
//                          blanked unless their decimal point is set.
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned CNT_W          = 16,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam logic [1:0]       DIG0      = 2'd0;
  localparam logic [1:0]       DIG1      = 2'd1;
  localparam logic [1:0]       DIG2      = 2'd2;
  localparam logic [1:0]       DIG3      = 2'd3;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       SEL_INV   = SEL_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  // One-hot enable for a digit index (active-high form).
  function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      DIG0:    oh = 4'b0001;
      DIG1:    oh = 4'b0010;
      DIG2:    oh = 4'b0100;
      DIG3:    oh = 4'b1000;
      default: oh = 4'b0001;
    endcase
    return oh;
  endfunction

  // Nibble of the display word belonging to a digit index.
  function automatic logic [3:0] idx_nibble(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      DIG0:    nib = word[3:0];
      DIG1:    nib = word[7:4];
      DIG2:    nib = word[11:8];
      DIG3:    nib = word[15:12];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  logic [CNT_W-1:0] slot_cnt_r;
  logic [CNT_W-1:0] slot_cnt_nxt_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_nxt_s;
  logic             slot_last_s;
  logic             boundary_s;
  logic             frame_done_r;
  logic             frame_done_nxt_s;

  logic [15:0]      act_data_r;
  logic [3:0]       act_dp_r;
  logic [3:0]       act_blink_r;
  logic [15:0]      pend_data_r;
  logic [3:0]       pend_dp_r;
  logic [3:0]       pend_blink_r;
  logic             upd_pending_r;
  logic [15:0]      act_data_nxt_s;
  logic [3:0]       act_dp_nxt_s;
  logic [3:0]       act_blink_nxt_s;

  logic [3:0]       blank_s;
  logic [3:0]       nib_nxt_s;
  logic             dp_nxt_s;
  logic             blink_nxt_s;
  logic [3:0]       onehot_nxt_s;

  logic [3:0]       digit_bin_r;
  logic             digit_dp_en_r;
  logic             digit_blink_r;
  logic [3:0]       digit_sel_r;

  assign slot_last_s = (slot_cnt_r == SLOT_LAST);
  assign boundary_s  = slot_last_s && (idx_r == DIG3);

  // Slot counter / digit index next state and the frame_done look-ahead.
  always_comb begin
    slot_cnt_nxt_s = slot_cnt_r + CNT_ONE;
    idx_nxt_s      = idx_r;
    if (slot_last_s) begin
      slot_cnt_nxt_s = {CNT_W{1'b0}};
      case (idx_r)
        DIG0:    idx_nxt_s = DIG1;
        DIG1:    idx_nxt_s = DIG2;
        DIG2:    idx_nxt_s = DIG3;
        DIG3:    idx_nxt_s = DIG0;
        default: idx_nxt_s = DIG0;
      endcase
    end else begin
      idx_nxt_s = idx_r;
    end
    frame_done_nxt_s = (idx_nxt_s == DIG3) && (slot_cnt_nxt_s == SLOT_LAST);
  end

  // Active buffer as it will be after this edge; outputs are built from it so
  // a boundary swap appears together with the digit-0 slot.
  always_comb begin
    act_data_nxt_s  = act_data_r;
    act_dp_nxt_s    = act_dp_r;
    act_blink_nxt_s = act_blink_r;
    if (boundary_s && upd_pending_r) begin
      act_data_nxt_s  = pend_data_r;
      act_dp_nxt_s    = pend_dp_r;
      act_blink_nxt_s = pend_blink_r;
    end else begin
      act_data_nxt_s  = act_data_r;
      act_dp_nxt_s    = act_dp_r;
      act_blink_nxt_s = act_blink_r;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero blanking: a digit blanks when it and every higher nibble is
  // zero, unless its decimal point is lit. Digit 0 always shows.
  always_comb begin
    blank_s[0] = 1'b0;
    blank_s[1] = (act_data_nxt_s[15:4]  == 12'h000) && !act_dp_nxt_s[1];
    blank_s[2] = (act_data_nxt_s[15:8]  == 8'h00)   && !act_dp_nxt_s[2];
    blank_s[3] = (act_data_nxt_s[15:12] == 4'h0)    && !act_dp_nxt_s[3];
  end
`else
  assign blank_s = 4'b0000;
`endif

  // Decoder-facing values for the slot that starts (or continues) after this edge.
  always_comb begin
    nib_nxt_s   = idx_nibble(act_data_nxt_s, idx_nxt_s);
    dp_nxt_s    = act_dp_nxt_s[idx_nxt_s];
    blink_nxt_s = act_blink_nxt_s[idx_nxt_s];
    if (blank_s[idx_nxt_s]) begin
      onehot_nxt_s = 4'b0000;
    end else begin
      onehot_nxt_s = idx_onehot(idx_nxt_s);
    end
  end

  // Scan timing: slot counter, digit index, frame_done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_r   <= {CNT_W{1'b0}};
      idx_r        <= DIG0;
      frame_done_r <= 1'b0;
    end else begin
      slot_cnt_r   <= slot_cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  // Double buffer: load always lands in pending; pending moves to active at a
  // boundary. A load on the boundary keeps upd_pending set for its new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_data_r    <= 16'h0000;
      act_dp_r      <= 4'b0000;
      act_blink_r   <= 4'b0000;
      pend_data_r   <= 16'h0000;
      pend_dp_r     <= 4'b0000;
      pend_blink_r  <= 4'b0000;
      upd_pending_r <= 1'b0;
    end else begin
      act_data_r  <= act_data_nxt_s;
      act_dp_r    <= act_dp_nxt_s;
      act_blink_r <= act_blink_nxt_s;
      if (bus.load) begin
        pend_data_r   <= bus.data_in;
        pend_dp_r     <= bus.dp_mask;
        pend_blink_r  <= bus.blink_mask;
        upd_pending_r <= 1'b1;
      end else if (boundary_s) begin
        upd_pending_r <= 1'b0;
      end else begin
        upd_pending_r <= upd_pending_r;
      end
    end
  end

  // Registered decoder outputs; all switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_bin_r   <= 4'h0;
      digit_dp_en_r <= 1'b0;
      digit_blink_r <= 1'b0;
      digit_sel_r   <= 4'b0001 ^ SEL_INV;
    end else begin
      digit_bin_r   <= nib_nxt_s;
      digit_dp_en_r <= dp_nxt_s;
      digit_blink_r <= blink_nxt_s;
      digit_sel_r   <= onehot_nxt_s ^ SEL_INV;
    end
  end

  assign bus.digit_bin   = digit_bin_r;
  assign bus.digit_dp_en = digit_dp_en_r;
  assign bus.digit_blink = digit_blink_r;
  assign bus.digit_sel   = digit_sel_r;
  assign bus.upd_pending = upd_pending_r;
  assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV=4: one active-high and one
// active-low instance share the same stimulus. A frame-position model
// (cycle count since reset) predicts every output on every negedge; a set of
// literal expectations pins the model to hand-computed values.
module tb_seg_scan_ctrl;
  localparam int SD = 4;
  localparam int FR = 4 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0] dp_mask = 4'b0000;
  logic [3:0] blink_mask = 4'b0000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl_if bus_h ();
  seg_scan_ctrl_if bus_l ();
  assign bus_h.load = load;       assign bus_l.load = load;
  assign bus_h.data_in = data_in; assign bus_l.data_in = data_in;
  assign bus_h.dp_mask = dp_mask; assign bus_l.dp_mask = dp_mask;
  assign bus_h.blink_mask = blink_mask; assign bus_l.blink_mask = blink_mask;

  seg_scan_ctrl #(.SCAN_DIV(SD), .CNT_W(4), .SEL_ACTIVE_LOW(1'b0)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
  seg_scan_ctrl #(.SCAN_DIV(SD), .CNT_W(4), .SEL_ACTIVE_LOW(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frame position + double buffer ----------------
  int cyc;
  logic [15:0] m_act, m_pend;
  logic [3:0] m_act_dp, m_act_bl, m_pend_dp, m_pend_bl;
  logic m_upd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; m_upd <= 1'b0;
      m_act <= 16'h0; m_act_dp <= 4'h0; m_act_bl <= 4'h0;
      m_pend <= 16'h0; m_pend_dp <= 4'h0; m_pend_bl <= 4'h0;
    end else begin
      cyc <= cyc + 1;
      if ((cyc % FR == FR - 1) && m_upd) begin
        m_act <= m_pend; m_act_dp <= m_pend_dp; m_act_bl <= m_pend_bl;
      end
      if (load) begin
        m_pend <= data_in; m_pend_dp <= dp_mask; m_pend_bl <= blink_mask; m_upd <= 1'b1;
      end else if (cyc % FR == FR - 1) begin
        m_upd <= 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : cmp_proc
    int idx;
    logic [15:0] hi;
    logic blank;
    logic [3:0] e_sel;
    idx = (cyc / SD) % 4;
    hi = m_act >> (4 * idx);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != 0) && (hi == 16'h0000) && !m_act_dp[idx];
`endif
    e_sel = blank ? 4'b0000 : (4'b0001 << idx);
    check("m_bin_h", bus_h.digit_bin, hi[3:0]);
    check("m_dp_h", bus_h.digit_dp_en, m_act_dp[idx]);
    check("m_blink_h", bus_h.digit_blink, m_act_bl[idx]);
    check("m_sel_h", bus_h.digit_sel, e_sel);
    check("m_upd_h", bus_h.upd_pending, m_upd);
    check("m_fd_h", bus_h.frame_done, (cyc % FR) == (FR - 1));
    check("m_bin_l", bus_l.digit_bin, hi[3:0]);
    check("m_sel_l", bus_l.digit_sel, ~e_sel & 4'hF);
    check("m_fd_l", bus_l.frame_done, (cyc % FR) == (FR - 1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    load = 1'b1; data_in = d; dp_mask = dp; blink_mask = bl;
    @(posedge clk); #2;
    load = 1'b0;
  endtask

  // Advance to the point just after the edge that puts the frame at phase ph.
  task automatic wait_phase(input int ph);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3 * FR; k++) begin
      @(posedge clk); #2;
      if (cyc % FR == ph) begin ok = 1'b1; break; end
    end
    check("wait_phase_timeout", ok, 1'b1);
  endtask

  // Stop at the negedge of the first digit-0 cycle that shows the given word.
  task automatic wait_shown(input logic [15:0] d, input logic [3:0] dp);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 5 * FR; k++) begin
      @(negedge clk);
      if (cyc % FR == 0 && m_act == d && m_act_dp == dp) begin ok = 1'b1; break; end
    end
    check("wait_shown_timeout", ok, 1'b1);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] bin_tab [4];
    logic [3:0] sel_tab [4];
    logic [3:0] blank2_sel, blank3_sel;
    int a_seen;
    bin_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
    sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef LEADING_ZERO_BLANK_EN
    blank2_sel = 4'b0000; blank3_sel = 4'b0000;
`else
    blank2_sel = 4'b0100; blank3_sel = 4'b1000;
`endif

    // Reset values, then 4 cycles on digit 0 after release.
    repeat (3) begin @(posedge clk); #2; end
    check("rst_sel_h", bus_h.digit_sel, 4'b0001);
    check("rst_sel_l", bus_l.digit_sel, 4'b1110);
    check("rst_bin", bus_h.digit_bin, 4'h0);
    check("rst_upd", bus_h.upd_pending, 1'b0);
    check("rst_fd", bus_h.frame_done, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_sel", bus_h.digit_sel, 4'b0001);
    end
    @(negedge clk);
    check("first_adv_sel", bus_h.digit_sel, 4'b0010);

    // Scan with masks.
    do_load(16'h1234, 4'b0100, 4'b1000);
    check("upd_after_load", bus_h.upd_pending, 1'b1);
    wait_shown(16'h1234, 4'b0100);
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      check("scan_bin", bus_h.digit_bin, bin_tab[i / SD]);
      check("scan_sel", bus_h.digit_sel, sel_tab[i / SD]);
      check("scan_sel_l", bus_l.digit_sel, ~sel_tab[i / SD] & 4'hF);
      check("scan_dp", bus_h.digit_dp_en, (i / SD) == 2);
      check("scan_blink", bus_h.digit_blink, (i / SD) == 3);
      check("scan_fd", bus_h.frame_done, i == FR - 1);
    end

    // Double buffer: second load in the same frame overwrites the first.
    @(negedge clk);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    do_load(16'h5555, 4'b0000, 4'b0000);
    a_seen = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      if (bus_h.digit_bin == 4'hA) a_seen++;
    end
    check("never_aaaa", a_seen, 0);
    check("shows_5555", bus_h.digit_bin, 4'h5);

    // Load coincident with the boundary while pending is full.
    do_load(16'h1111, 4'b0000, 4'b0000);
    wait_phase(FR - 1);
    do_load(16'h2222, 4'b0000, 4'b0000);
    check("coinc_upd_stays", bus_h.upd_pending, 1'b1);
    @(negedge clk);
    check("coinc_prior_shown", bus_h.digit_bin, 4'h1);
    wait_shown(16'h2222, 4'b0000);
    check("coinc_new_shown", bus_h.digit_bin, 4'h2);
    check("coinc_upd_clear", bus_h.upd_pending, 1'b0);

    // Load on the boundary with nothing pending waits a full frame.
    wait_phase(FR - 1);
    do_load(16'h3333, 4'b0000, 4'b0000);
    @(negedge clk);
    check("idle_coinc_old", bus_h.digit_bin, 4'h2);
    check("idle_coinc_upd", bus_h.upd_pending, 1'b1);
    wait_shown(16'h3333, 4'b0000);
    check("idle_coinc_new", bus_h.digit_bin, 4'h3);

    // Asynchronous reset mid-slot discards pending data.
    do_load(16'h7777, 4'b0000, 4'b0000);
    wait_phase(6);
    rst = 1'b1;
    #1;
    check("arst_sel_h", bus_h.digit_sel, 4'b0001);
    check("arst_sel_l", bus_l.digit_sel, 4'b1110);
    check("arst_bin", bus_h.digit_bin, 4'h0);
    check("arst_upd", bus_h.upd_pending, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2 * FR + 3) @(negedge clk);
    check("arst_discard_bin", bus_h.digit_bin, 4'h0);
    check("arst_discard_upd", bus_h.upd_pending, 1'b0);

    // Leading-zero blanking (or plain drive when the option is off).
    do_load(16'h0070, 4'b0000, 4'b0000);
    wait_shown(16'h0070, 4'b0000);
    repeat (2 * SD) @(negedge clk);
    check("blank_idx2_sel", bus_h.digit_sel, blank2_sel);
    check("blank_idx2_sel_l", bus_l.digit_sel, ~blank2_sel & 4'hF);
    repeat (SD) @(negedge clk);
    check("blank_idx3_sel", bus_h.digit_sel, blank3_sel);
    do_load(16'h0070, 4'b0100, 4'b0000);
    wait_shown(16'h0070, 4'b0100);
    repeat (SD) @(negedge clk);
    check("dp_idx1_bin", bus_h.digit_bin, 4'h7);
    repeat (SD) @(negedge clk);
    check("dp_idx2_sel", bus_h.digit_sel, 4'b0100);
    check("dp_idx2_bin", bus_h.digit_bin, 4'h0);
    check("dp_idx2_dp", bus_h.digit_dp_en, 1'b1);
    repeat (SD) @(negedge clk);
    check("dp_idx3_sel", bus_h.digit_sel, blank3_sel);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
